muldiv_unit: RTL
================

# muldiv_unit

Multi-cycle RV32M multiply/divide unit for the Execute stage, alongside the combinational `alu`. It accepts one operation through a valid/ready handshake and computes it iteratively, one bit per cycle. It applies RISC-V sign, divide-by-zero and overflow rules, then presents the result for exactly one cycle. The pipeline stalls on `busy_o` and cancels in-flight work with `flush_i`.

## Interface
- `DATA_WIDTH`, default 32 (from `defines`): operand/result width; power of two, ≥ 8.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `flush_i`  in  1  abort current operation; discard its result.
- `valid_i`  in  1  request valid.
- `ready_o`  out  1  unit can accept; high only in IDLE.
- `mdu_op_i`  in  `mdu_op_e`  operation: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `operand1_i`  in  DATA_WIDTH  rs1 value (multiplicand / dividend).
- `operand2_i`  in  DATA_WIDTH  rs2 value (multiplier / divisor).
- `result_o`  out  DATA_WIDTH  result; registered; held until the next DONE.
- `result_valid_o`  out  1  one-cycle pulse when `result_o` is new.
- `busy_o`  out  1  high in CALC and DONE.

## Operation
- Accept on a rising edge with `valid_i && ready_o && !flush_i`. Latch the op, both operands, operand signs and magnitudes.
- Signedness of each operand follows the op:
  - MULH and DIV/REM: both signed.
  - MULHSU: operand1 signed, operand2 unsigned.
  - All others: both unsigned.
- States:
  - IDLE → CALC on accept.
  - IDLE → DONE on accept of a special case or a fast multiply.
  - CALC → DONE when the bit counter reaches DATA_WIDTH.
  - DONE → IDLE unconditionally.
  - flush_i forces any state → IDLE.
- Multiply: shift-add on magnitudes into a 2·DATA_WIDTH-bit product, one multiplier bit per CALC cycle.
  - Negate the full 2W product if the operand signs differ.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- Divide: restoring division on magnitudes, one quotient bit per CALC cycle.
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
- Special cases are decided at accept and skip CALC:
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → operand1.
  - Signed overflow (operand1 = most-negative, operand2 = all ones): DIV → operand1; REM → 0.
- Counter is `$clog2(DATA_WIDTH)+1` bits. Clear on accept, increment each CALC cycle; no wrap past DATA_WIDTH.
- `result_o` is written only in the cycle entering DONE. `result_valid_o` is high exactly in DONE.

## Timing
- Reset: state IDLE, `ready_o`=1, `busy_o`=0, `result_valid_o`=0, `result_o`=0, counter 0. Reset mid-operation drops the op with no pulse.
- Iterative latency: accept at edge N → `result_valid_o` high in cycle N+DATA_WIDTH+1 (33 for W=32).
- Special case or fast multiply: `result_valid_o` high in cycle N+1.
- Back-to-back throughput: after DONE, `ready_o` rises in the next cycle, giving at most one op per DATA_WIDTH+2 cycles.
- `valid_i` while `ready_o`=0 is ignored; the requester must hold it.
- Simultaneous `flush_i` and `valid_i` in IDLE: not accepted.
- `flush_i` in DONE suppresses nothing already visible: the pulse in that cycle stands, and the state goes to IDLE next.
- `rst` takes priority over `flush_i`, which takes priority over accept.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: all four multiply ops use a single-cycle `*` on (W+1)-bit sign-extended operands. They go IDLE → DONE with latency 1; divides stay iterative.
- Not defined: multiplies use the iterative path, latency DATA_WIDTH+1; no hardware multiplier is inferred.

## Structure
- In package `defines`:
  - `mdu_op_e` enum.
  - `mdu_state_e` (IDLE, CALC, DONE).
  - `MDU_CNT_WIDTH` = `$clog2(DATA_WIDTH)+1`.
- One sub-module, `mdu_operand_prep` (combinational): per-op signedness, sign bits, magnitudes, divide-by-zero and overflow flags. Instantiated once in `muldiv_unit`.

## Test plan
- MUL 7 × 0xFFFFFFFD: → 0xFFFFFFEB; `result_valid_o` one cycle, exactly 33 cycles after accept (1 with `MULDIV_FAST_MUL_EN`).
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −20 / 3 → 0xFFFFFFFA; REM −20 / 3 → 0xFFFFFFFE; DIVU 20 / 3 → 6; REMU 20 / 3 → 2.
- Edge cases, each with latency 1:
  - DIVU 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
- `flush_i` 10 cycles after accepting a DIV: no `result_valid_o`; `ready_o`=1 next cycle; a following MUL 3 × 4 → 12 with correct latency.
- `rst` asserted mid-CALC: next cycle all outputs at reset values. `valid_i` with `flush_i` in IDLE: not accepted, `busy_o` stays 0.

Source files
------------

// File: rtl/defines_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Provides the operation and state enums, the default datapath width, the
// iteration counter width and small op-decode helpers.
package defines;

    localparam int unsigned MDU_DATA_WIDTH = 32;
    localparam int unsigned MDU_CNT_WIDTH  = $clog2(MDU_DATA_WIDTH) + 1;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    // Any of the four multiply flavours.
    function automatic logic mdu_is_mul(input mdu_op_e op);
        return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU};
    endfunction

    // Remainder flavours (result comes from the remainder register).
    function automatic logic mdu_is_rem(input mdu_op_e op);
        return op inside {MDU_REM, MDU_REMU};
    endfunction

endpackage

// File: rtl/mdu_operand_prep.sv
// Combinational operand conditioning for muldiv_unit.
// Ports:
//   op_i                    operation being requested
//   operand1_i, operand2_i  raw rs1 / rs2 values
//   sign1_c, sign2_c        operand is treated signed and is negative
//   mag1_c, mag2_c          absolute values under the op's signedness
//   div_zero_c              divide/remainder with a zero divisor
//   div_ovf_c               signed most-negative / -1 overflow
module mdu_operand_prep
    import defines::*;
#(
    parameter int unsigned DATA_WIDTH = MDU_DATA_WIDTH
) (
    input  mdu_op_e                 op_i,
    input  logic [DATA_WIDTH-1:0]   operand1_i,
    input  logic [DATA_WIDTH-1:0]   operand2_i,
    output logic                    sign1_c,
    output logic                    sign2_c,
    output logic [DATA_WIDTH-1:0]   mag1_c,
    output logic [DATA_WIDTH-1:0]   mag2_c,
    output logic                    div_zero_c,
    output logic                    div_ovf_c
);

    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic op1_signed;
    logic op2_signed;
    logic is_div;

    // Per-op signedness of each operand.
    always_comb begin
        op1_signed = 1'b0;
        op2_signed = 1'b0;
        case (op_i)
            MDU_MULH, MDU_DIV, MDU_REM: begin
                op1_signed = 1'b1;
                op2_signed = 1'b1;
            end
            MDU_MULHSU: op1_signed = 1'b1;
            default: ;
        endcase
    end

    // Signs, magnitudes and the two divide special cases.
    always_comb begin
        is_div     = !mdu_is_mul(op_i);
        sign1_c    = op1_signed & operand1_i[DATA_WIDTH-1];
        sign2_c    = op2_signed & operand2_i[DATA_WIDTH-1];
        mag1_c     = sign1_c ? -operand1_i : operand1_i;
        mag2_c     = sign2_c ? -operand2_i : operand2_i;
        div_zero_c = is_div && (operand2_i == '0);
        // Only signed DIV/REM can overflow; MULH shares the signedness but not the rule.
        div_ovf_c  = is_div && op1_signed && op2_signed &&
                     (operand1_i == MOST_NEG) && (&operand2_i);
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// One operation is accepted through valid/ready, computed one bit per cycle
// (shift-add multiply, restoring divide on magnitudes), sign-corrected and
// presented for exactly one cycle.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush_i           abort in-flight work, discard its result
//   valid_i/ready_o   request handshake (ready only in IDLE)
//   mdu_op_i          MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   operand1_i/2_i    rs1 / rs2
//   result_o          registered result, held until the next DONE
//   result_valid_o    one-cycle pulse when result_o is new
//   busy_o            high in CALC and DONE
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle multiplier for all
// multiply ops; divides stay iterative.
module muldiv_unit
    import defines::*;
#(
    parameter int unsigned DATA_WIDTH = MDU_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  mdu_op_e                 mdu_op_i,
    input  logic [DATA_WIDTH-1:0]   operand1_i,
    input  logic [DATA_WIDTH-1:0]   operand2_i,
    output logic [DATA_WIDTH-1:0]   result_o,
    output logic                    result_valid_o,
    output logic                    busy_o
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

    mdu_state_e         state_q, state_d;
    mdu_op_e            op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]     acc_q, acc_d;      // product, or {remainder, quotient}
    logic [W-1:0]       opb_q, opb_d;      // multiplicand or divisor magnitude
    logic               neg_q, neg_d;      // negate product / quotient
    logic               rem_neg_q, rem_neg_d;
    logic [W-1:0]       result_q, result_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic               sign1_c, sign2_c;
    logic [W-1:0]       mag1_c, mag2_c;
    logic               div_zero_c, div_ovf_c;

    logic               accept;
    logic [W:0]         mul_sum;
    logic [2*W-1:0]     mul_acc_nxt;
    logic [W:0]         div_shift;
    logic [2*W-1:0]     div_acc_nxt;
    logic [2*W-1:0]     step_acc;
    logic [2*W-1:0]     prod_fin;
    logic [W-1:0]       quot_fin;
    logic [W-1:0]       rem_fin;
    logic [W-1:0]       final_result;
    logic [W-1:0]       special_result;

    mdu_operand_prep #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_prep (
        .op_i       (mdu_op_i),
        .operand1_i (operand1_i),
        .operand2_i (operand2_i),
        .sign1_c    (sign1_c),
        .sign2_c    (sign2_c),
        .mag1_c     (mag1_c),
        .mag2_c     (mag2_c),
        .div_zero_c (div_zero_c),
        .div_ovf_c  (div_ovf_c)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*W-1:0] fast_a;
    logic signed [2*W-1:0] fast_b;
    logic        [2*W-1:0] fast_prod;
    logic        [W-1:0]   fast_result;

    // Single-cycle multiply on (W+1)-bit sign-extended operands; the low 2W
    // bits of the product are exact for every signedness combination.
    always_comb begin
        fast_a      = (2*W)'($signed({sign1_c, operand1_i}));
        fast_b      = (2*W)'($signed({sign2_c, operand2_i}));
        fast_prod   = fast_a * fast_b;
        fast_result = (mdu_op_i == MDU_MUL) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
    end
`endif

    // One iteration of each datapath, plus the sign-corrected final result.
    always_comb begin
        mul_sum     = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_acc_nxt = {mul_sum, acc_q[W-1:1]};

        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        if (div_shift >= {1'b0, opb_q}) begin
            div_acc_nxt = {W'(div_shift - {1'b0, opb_q}), acc_q[W-2:0], 1'b1};
        end else begin
            div_acc_nxt = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
        end

        step_acc = mdu_is_mul(op_q) ? mul_acc_nxt : div_acc_nxt;
        prod_fin = neg_q ? -step_acc : step_acc;
        quot_fin = neg_q ? -step_acc[W-1:0] : step_acc[W-1:0];
        rem_fin  = rem_neg_q ? -step_acc[2*W-1:W] : step_acc[2*W-1:W];

        case (op_q)
            MDU_MUL:                          final_result = prod_fin[W-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  final_result = prod_fin[2*W-1:W];
            MDU_DIV, MDU_DIVU:                final_result = quot_fin;
            MDU_REM, MDU_REMU:                final_result = rem_fin;
            default:                          final_result = '0;
        endcase
    end

    // Divide-by-zero and overflow results, decided from the incoming request.
    always_comb begin
        if (mdu_is_rem(mdu_op_i)) begin
            special_result = div_zero_c ? operand1_i : '0;
        end else begin
            special_result = div_zero_c ? '1 : operand1_i;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        accept    = valid_i && ready_q && !flush_i;

        if (flush_i) begin
            state_d = MDU_IDLE;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (accept) begin
                        op_d      = mdu_op_i;
                        cnt_d     = '0;
                        neg_d     = sign1_c ^ sign2_c;
                        rem_neg_d = sign1_c;
                        if (div_zero_c || div_ovf_c) begin
                            result_d = special_result;
                            state_d  = MDU_DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (mdu_is_mul(mdu_op_i)) begin
                            result_d = fast_result;
                            state_d  = MDU_DONE;
                        end
`endif
                        else begin
                            // Multiply walks the multiplier from acc LSB; divide
                            // shifts the dividend out of the quotient half.
                            opb_d   = mdu_is_mul(mdu_op_i) ? mag1_c : mag2_c;
                            acc_d   = {{W{1'b0}}, mdu_is_mul(mdu_op_i) ? mag2_c : mag1_c};
                            state_d = MDU_CALC;
                        end
                    end
                end
                MDU_CALC: begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(W - 1)) begin
                        result_d = final_result;
                        state_d  = MDU_DONE;
                    end
                end
                MDU_DONE: state_d = MDU_IDLE;
                default:  state_d = MDU_IDLE;
            endcase
        end

        valid_d = (state_d == MDU_DONE);
        ready_d = (state_d == MDU_IDLE);
        busy_d  = (state_d != MDU_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MDU_IDLE;
            op_q      <= MDU_MUL;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign result_o       = result_q;
    assign result_valid_o = valid_q;
    assign ready_o        = ready_q;
    assign busy_o         = busy_q;

endmodule
